fetch_if_id: RTL

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the hazard unit and decode.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Latches fetched instructions into IF/ID and exports rs/rt fields to the hazard unit.
- Obeys the hazard unit's pc_write/if_id_write stall controls and the EX-stage branch/jump redirect.

---
 rtl/fetch_if_id_pkg.sv | 18 +
 rtl/fetch_if_id_if_id_reg.sv | 42 ++++
 rtl/fetch_if_id.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fetch_if_id_pkg.sv
// Shared types and constants for the instruction-fetch stage and IF/ID register.
package fetch_if_id_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_HOLD    = 2'd2,
      S_DISCARD = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

endpackage

// File: rtl/fetch_if_id_if_id_reg.sv
// IF/ID pipeline register: write-enable holds contents, flush (dominant) turns it into a NOP.
module if_id_reg
   import fetch_if_id_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic              flush_i,
   input  logic [31:0]       instr_i,
   input  logic [ADDR_W-1:0] pc4_i,
   output logic              valid_o,
   output logic [31:0]       instr_o,
   output logic [ADDR_W-1:0] pc4_o
);

   logic              valid_q;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] pc4_q;

   // pc4 is left alone on flush; it is meaningless while valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc4_q   <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
      end else if (we_i) begin
         valid_q <= 1'b1;
         instr_q <= instr_i;
         pc4_q   <= pc4_i;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_if_id.sv
// Instruction fetch + IF/ID register with single-outstanding imem requests.
// Optional IF_PERF_CNT_EN adds saturating stall/flush counters.
module fetch_if_id
   import fetch_if_id_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pc_write_i,
   input  logic              if_id_write_i,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_ready_i,
   input  logic [31:0]       imem_rdata_i,
   output logic              if_id_valid_o,
   output logic [31:0]       if_id_instr_o,
   output logic [ADDR_W-1:0] if_id_pc4_o,
   output logic [4:0]        if_id_rs_o,
   output logic [4:0]        if_id_rt_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cnt_o,
   output logic [31:0]       perf_flush_cnt_o
`endif
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;
   logic [31:0]       hold_q, hold_d;
   logic              imem_req_q;

   logic              avail, xfer;
   logic [31:0]       avail_instr;
   logic [ADDR_W-1:0] pc4, redir_pc, pc_adv;
   logic              unused_redir_lsb;

   assign unused_redir_lsb = ^redirect_pc_i[1:0];
   assign redir_pc    = {redirect_pc_i[ADDR_W-1:2], 2'b00};
   assign pc4         = pc_q + ADDR_W'(4);
   assign pc_adv      = pc_write_i ? pc4 : pc_q;
   assign avail       = ((state_q == S_FETCH) && imem_ready_i) || (state_q == S_HOLD);
   assign avail_instr = (state_q == S_HOLD) ? hold_q : imem_rdata_i;
   assign xfer        = avail && if_id_write_i && !redirect_valid_i;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      disc_addr_d = disc_addr_q;
      hold_d      = hold_q;
      if (redirect_valid_i) begin
         pc_d   = redir_pc;
         hold_d = NOP_INSTR;
         unique case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH: begin
               // An unanswered request must still be drained at its old address.
               if (imem_ready_i) state_d = S_FETCH;
               else begin
                  state_d     = S_DISCARD;
                  disc_addr_d = pc_q;
               end
            end
            S_HOLD:    state_d = S_FETCH;
            S_DISCARD: state_d = S_DISCARD;
            default:   state_d = S_IDLE;
         endcase
      end else begin
         unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
               if (imem_ready_i) begin
                  if (if_id_write_i) pc_d = pc_adv;
                  else begin
                     hold_d  = imem_rdata_i;
                     state_d = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (if_id_write_i) begin
                  pc_d    = pc_adv;
                  state_d = S_FETCH;
               end
            end
            S_DISCARD: if (imem_ready_i) state_d = S_FETCH;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         disc_addr_q <= '0;
         hold_q      <= NOP_INSTR;
         imem_req_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         disc_addr_q <= disc_addr_d;
         hold_q      <= hold_d;
         imem_req_q  <= (state_d == S_FETCH) || (state_d == S_DISCARD);
      end
   end

   assign imem_req_o  = imem_req_q;
   assign imem_addr_o = (state_q == S_DISCARD) ? disc_addr_q : pc_q;

   if_id_reg #(.ADDR_W(ADDR_W)) u_if_id_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (xfer),
      .flush_i (redirect_valid_i),
      .instr_i (avail_instr),
      .pc4_i   (pc4),
      .valid_o (if_id_valid_o),
      .instr_o (if_id_instr_o),
      .pc4_o   (if_id_pc4_o)
   );

   assign if_id_rs_o = if_id_instr_o[RS_MSB:RS_LSB];
   assign if_id_rt_o = if_id_instr_o[RT_MSB:RT_LSB];

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!if_id_write_i && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (redirect_valid_i && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign perf_stall_cnt_o = stall_cnt_q;
   assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule
